// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ALL      = 1'b0;
    localparam logic MODE_MINTERMS = 1'b1;

endpackage

// File: rtl/tt_row_counter.sv
// Row counter with one spare MSB so the step past the last row never wraps to 0.
module tt_row_counter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'((1 << (WIDTH - 1)) - 1);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a latched truth table row by row, emitting valid/ready beats and
// counting minterms; flags constant-0 / constant-1 functions at the end.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [(2**N_IN)-1:0] tt,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      out_idx,
    output logic                 out_s,
    output logic                 done,
    output logic [N_IN:0]        ones_count,
    output logic                 const0,
    output logic                 const1
);

    localparam int ROWS = 2**N_IN;

    state_t          r_state;
    state_t          w_next;
    logic [ROWS-1:0] r_tt;
    logic            r_mode;
    logic [N_IN:0]   r_ones;
    logic            r_c0;
    logic            r_c1;

    logic [N_IN:0]   w_row;
    logic            w_last;
    logic            w_cur;
    logic            w_valid;
    logic            w_adv;
    logic            w_accept;
    logic            w_hs;
    logic [N_IN:0]   w_ones_next;

    tt_row_counter #(.WIDTH(N_IN + 1)) u_row (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_accept),
        .i_en    (w_adv),
        .o_count (w_row),
        .o_last  (w_last)
    );

    assign w_cur = r_tt[w_row[N_IN-1:0]];

    // Next state; zero-valued rows in minterm mode advance without a beat.
    always_comb begin
        w_next   = r_state;
        w_valid  = 1'b0;
        w_adv    = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = SWEEP;
                end else begin
                    w_next = IDLE;
                end
            end
            SWEEP: begin
                w_valid = !w_row[N_IN] && ((r_mode == MODE_ALL) || w_cur);
                w_adv   = w_valid ? out_ready : 1'b1;
                if (w_adv && w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = SWEEP;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_hs        = w_valid & out_ready;
    assign w_ones_next = r_ones + ((w_hs && w_cur) ? (N_IN+1)'(1) : (N_IN+1)'(0));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sweep context latched on accept; constant flags resolved on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tt   <= '0;
            r_mode <= MODE_ALL;
            r_ones <= '0;
            r_c0   <= 1'b0;
            r_c1   <= 1'b0;
        end else if (w_accept) begin
            r_tt   <= tt;
            r_mode <= mode;
            r_ones <= '0;
            r_c0   <= 1'b0;
            r_c1   <= 1'b0;
        end else if ((r_state == SWEEP) && (w_next == DONE)) begin
            r_ones <= w_ones_next;
            r_c0   <= (w_ones_next == '0);
            r_c1   <= (w_ones_next == (N_IN+1)'(ROWS));
        end else begin
            r_ones <= w_ones_next;
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign out_valid  = w_valid;
    assign out_idx    = w_row[N_IN-1:0];
    assign out_s      = (r_state == SWEEP) & w_cur;
    assign ones_count = r_ones;
    assign const0     = r_c0;
    assign const1     = r_c1;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Table-driven bench with a beat scoreboard for truth_table_sweeper (N_IN=3).
module tb_truth_table_sweeper;

    localparam int N_IN = 3;
    localparam int ROWS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] tt;
    logic       out_ready;
    logic       busy;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_s;
    logic       done;
    logic [3:0] ones_count;
    logic       const0;
    logic       const1;

    truth_table_sweeper #(.N_IN(N_IN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .tt         (tt),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_s      (out_s),
        .done       (done),
        .ones_count (ones_count),
        .const0     (const0),
        .const1     (const1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tt;
        logic       mode;
        int         stall_lo;
        int         stall_hi;
        int         glitch;
        int         done_cyc;
        int         ones;
        logic       c0;
        logic       c1;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic       s;
    } beat_t;

    vec_t  vecs[8];
    beat_t sbq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_sweep(input vec_t v, input string name);
        bit         seen_done;
        bit         holding;
        logic [2:0] held_idx;
        beat_t      b;
        sbq.delete();
        for (int i = 0; i < ROWS; i++) begin
            if (v.mode == 1'b0 || v.tt[i]) begin
                sbq.push_back('{idx: 3'(i), s: v.tt[i]});
            end
        end
        @(negedge clk);
        tt = v.tt; mode = v.mode; start = 1'b1; out_ready = 1'b1;
        seen_done = 0;
        holding   = 0;
        held_idx  = 3'd0;
        for (int cyc = 1; cyc <= 40 && !seen_done; cyc++) begin
            @(negedge clk);
            start = (cyc == v.glitch);
            if (cyc == v.glitch) tt = 8'hFF;
            out_ready = !(cyc >= v.stall_lo && cyc <= v.stall_hi);
            if (holding) begin
                chk({name, " hold_idx"}, 32'(out_idx), 32'(held_idx));
                chk({name, " hold_valid"}, 32'(out_valid), 32'd1);
            end
            holding = 0;
            if (done) begin
                seen_done = 1;
                chk({name, " done_cycle"}, 32'(cyc), 32'(v.done_cyc));
                chk({name, " ones_count"}, 32'(ones_count), 32'(v.ones));
                chk({name, " const0"}, 32'(const0), 32'(v.c0));
                chk({name, " const1"}, 32'(const1), 32'(v.c1));
                chk({name, " done_valid"}, 32'(out_valid), 32'd0);
            end else begin
                chk({name, " busy"}, 32'(busy), 32'd1);
                if (out_valid) begin
                    if (out_ready) begin
                        if (sbq.size() == 0) begin
                            chk({name, " extra_beat"}, 32'(out_idx), 32'hFFFF);
                        end else begin
                            b = sbq.pop_front();
                            chk({name, " beat_idx"}, 32'(out_idx), 32'(b.idx));
                            chk({name, " beat_s"}, 32'(out_s), 32'(b.s));
                        end
                    end else begin
                        holding  = 1;
                        held_idx = out_idx;
                    end
                end
            end
        end
        if (!seen_done) chk({name, " done_timeout"}, 32'd0, 32'd1);
        chk({name, " beats_left"}, 32'(sbq.size()), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({name, " idle_busy"}, 32'(busy), 32'd0);
        chk({name, " held_flags"}, {28'd0, ones_count}, 32'(v.ones));
        chk({name, " held_const"}, {30'd0, const0, const1}, {30'd0, v.c0, v.c1});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h02, 1'b0, 100, 0, 0,  9, 1, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 1'b1, 100, 0, 0,  9, 1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0,   2, 4, 0, 12, 8, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 100, 0, 0,  9, 0, 1'b1, 1'b0};
        vecs[4] = '{8'h02, 1'b0, 100, 0, 4,  9, 1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 100, 0, 0,  9, 0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 100, 0, 0,  9, 8, 1'b0, 1'b1};
        vecs[7] = '{8'hA5, 1'b1,   3, 3, 0, 10, 4, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; mode = 1'b0; tt = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", {19'd0, busy, out_valid, out_idx, out_s, done, ones_count, const0, const1}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            do_sweep(vecs[k], $sformatf("vec%0d", k));
        end

        // Asynchronous reset in the middle of row 3, then a clean rerun.
        @(negedge clk);
        tt = 8'h02; mode = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10 && out_idx != 3'd3; c++) @(negedge clk);
        chk("rst_reach_row3", 32'(out_idx), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {19'd0, busy, out_valid, out_idx, out_s, done, ones_count, const0, const1}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", 32'(busy), 32'd0);
        do_sweep(vecs[0], "restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 3, number of Boolean inputs, legal range 1..8.
REQ-002 SHALL have parameter ROWS, derived as 2**N_IN, not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 mode  input  1  0 = emit every row; 1 = emit only minterms (rows where the function is 1).
REQ-007 tt  input  ROWS  truth table; tt[i] = function value for input vector i (i[N_IN-1] = first variable x, i[0] = last variable).
REQ-008 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-009 out_valid  output  1  row beat valid.
REQ-010 out_ready  input  1  consumer accepts beat; a handshake is out_valid & out_ready on the same edge.
REQ-011 out_idx  output  N_IN  input vector of current beat.
REQ-012 out_s  output  1  function value of current beat.
REQ-013 done  output  1  one-cycle pulse at end of sweep.
REQ-014 ones_count  output  N_IN+1  number of rows with value 1 in last or current sweep.
REQ-015 const0 / const1  output  1 each  function identically 0 / 1; updated in DONE and held until next start.

Function
REQ-016 SHALL implement FSM states IDLE, SWEEP, DONE; IDLE->SWEEP on start, SWEEP->DONE after last row, DONE->IDLE unconditionally.
REQ-017 On accepted start SHALL latch tt and mode, clear ones_count, const0, const1, and set row counter to 0; later changes to tt/mode SHALL not affect the sweep.
REQ-018 start while busy SHALL be ignored.
REQ-019 Mode 0: each SWEEP row SHALL present out_valid=1, out_idx=row, out_s=tt_latched[row]; row advances only on handshake.
REQ-020 While out_valid=1 and out_ready=0, out_idx and out_s SHALL hold stable.
REQ-021 Mode 1: rows with value 0 SHALL be skipped internally at one row per cycle with out_valid=0; rows with value 1 SHALL be presented as in REQ-019.
REQ-022 ones_count SHALL increment by 1 when a value-1 row is retired (handshake), in both modes.
REQ-023 Row counter SHALL be N_IN+1 bits wide so ROWS-1 -> ROWS is detected without wrap to 0; last row = ROWS-1.
REQ-024 Latency with out_ready tied 1, mode 0: start at cycle 0, first beat cycle 1, last beat cycle ROWS, done cycle ROWS+1, start accepted again cycle ROWS+2.
REQ-025 In DONE: const0 = (ones_count==0), const1 = (ones_count==ROWS); out_valid=0.
REQ-026 Mode 1 with all-zero table: no beats, done at cycle ROWS+1, const0=1.

Reset
REQ-027 rst SHALL asynchronously force IDLE and busy=0, out_valid=0, out_idx=0, out_s=0, done=0, ones_count=0, const0=0, const1=0.
REQ-028 rst mid-sweep SHALL abort without a done pulse; first start after rst release SHALL begin at row 0.

Structure
REQ-029 Shared package tt_sweep_pkg SHALL hold the state enum (IDLE, SWEEP, DONE) and mode constants MODE_ALL=0, MODE_MINTERMS=1.
REQ-030 Row counter with terminal detect SHALL be a sub-module tt_row_counter (width parameter, clear, enable, last flag).

Verification
REQ-031 N_IN=3, tt=8'b0000_0010, mode 0, out_ready=1 -> 8 beats idx 0..7, s=0,1,0,0,0,0,0,0; ones_count=1; done at cycle 9; const0=0, const1=0.
REQ-032 Same tt, mode 1 -> exactly one beat idx=3'b001, s=1; done at cycle 9; ones_count=1.
REQ-033 tt=8'hFF, mode 0, out_ready low cycles 2-4 -> idx=1 held stable cycles 2-4, advances cycle 5; done at cycle 12; const1=1.
REQ-034 tt=8'h00, mode 1 -> no out_valid; done at cycle 9; const0=1, ones_count=0.
REQ-035 start pulsed at cycle 4 during sweep, tt changed to 8'hFF mid-sweep -> ignored; outputs match REQ-031.
REQ-036 rst asserted asynchronously between edges during row 3 -> all outputs at reset values immediately, no done; restart reproduces REQ-031.
